// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver with a one-word holding register, valid/ready output and sticky overrun.
// Optional even-parity frame check is built when SIPO_PARITY_CHECK_EN is defined.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_in,
    input  logic             shift_en,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             parity_err
);

`ifdef SIPO_PARITY_CHECK_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int                CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] word_s;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             bit_take_s, data_bit_s, complete_s, load_s, drop_s;

`ifdef SIPO_PARITY_CHECK_EN
    logic             parity_q, parity_d;

    // Even parity over data and received parity bit: 1 flags a mismatch.
    function automatic logic parity_mismatch(input logic [WIDTH-1:0] data, input logic pbit);
        return (^data) ^ pbit;
    endfunction
`endif

    // Shift-register datapath for the selected bit order.
    always_comb begin
        shifted_s = shift_q;
        if (MSB_FIRST) begin
            shifted_s = {shift_q[WIDTH-2:0], serial_in};
        end else begin
            shifted_s = {serial_in, shift_q[WIDTH-1:1]};
        end
    end

    // Frame qualification: which accepted bit is data and which one completes the word.
    always_comb begin
        bit_take_s = shift_en && !sync_clr;
        complete_s = bit_take_s && (bit_cnt_q == LAST_CNT);
`ifdef SIPO_PARITY_CHECK_EN
        // The trailing parity bit is consumed but never enters the shift register.
        data_bit_s = bit_take_s && (bit_cnt_q != LAST_CNT);
        word_s     = shift_q;
`else
        data_bit_s = bit_take_s;
        word_s     = shifted_s;
`endif
        load_s     = complete_s && (!valid_q || out_ready);
        drop_s     = complete_s && valid_q && !out_ready;
    end

    // Next state of the serial side: shift register and bit counter.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (sync_clr) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else begin
            if (data_bit_s) begin
                shift_d = shifted_s;
            end else begin
                shift_d = shift_q;
            end
            if (complete_s) begin
                bit_cnt_d = '0;
            end else if (bit_take_s) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end
    end

    // Next state of the holding stage, handshake and sticky overrun.
    always_comb begin
        hold_d    = hold_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load_s) begin
            hold_d  = word_s;
            valid_d = 1'b1;
        end else if (out_ready) begin
            hold_d  = hold_q;
            valid_d = 1'b0;
        end else begin
            hold_d  = hold_q;
            valid_d = valid_q;
        end
        // Set beats clear when both land on the same edge.
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef SIPO_PARITY_CHECK_EN
    // Parity result is captured only alongside a word load.
    always_comb begin
        parity_d = parity_q;
        if (load_s) begin
            parity_d = parity_mismatch(shift_q, serial_in);
        end else begin
            parity_d = parity_q;
        end
    end

    // Parity result register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

    assign parallel_out = hold_q;
    assign out_valid    = valid_q;
    assign overrun      = overrun_q;
    assign busy         = (bit_cnt_q != '0);

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in/parallel-out receiver; the far end of the 4-bit PISO shift-register link.
- Collects one serial bit per qualified clock into a shift register and presents each completed word on a registered parallel output with a valid/ready handshake.
- One holding stage decouples the serial side from the consumer; a sticky flag reports overrun.

Parameters:
- WIDTH, 4, data bits per word (legal range 2..32).
- MSB_FIRST, 1: 1 = first received bit lands in parallel_out[WIDTH-1]; 0 = first bit lands in parallel_out[0].

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- serial_in  input  1  serial data bit, sampled only when shift_en=1.
- shift_en  input  1  bit strobe; one bit is accepted per posedge with shift_en=1.
- sync_clr  input  1  synchronous frame resync; discards the partial word.
- parallel_out  output  WIDTH  completed word, stable while out_valid=1.
- out_valid  output  1  word available in the holding register.
- out_ready  input  1  consumer accepts the word at the posedge where out_valid&&out_ready.
- busy  output  1  a partial word is in progress (bit_cnt != 0).
- overrun  output  1  sticky: a completed word was dropped.
- overrun_clr  input  1  synchronous clear of overrun.
- parity_err  output  1  parity result for the held word; 0 when the feature is absent.

Behaviour:
- Reset (reset_n=0, asynchronous): shift register=0, bit_cnt=0, parallel_out=0, out_valid=0, busy=0, overrun=0, parity_err=0. Reset asserted mid-word discards all partial state.
- Accepting bits: each posedge with shift_en=1 shifts serial_in in and increments bit_cnt.
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
- Frame length N = WIDTH, or WIDTH+1 with parity enabled.
- Word complete: the posedge that accepts bit N.
  - bit_cnt wraps to 0 at that same edge.
  - The assembled word goes to parallel_out and out_valid=1, both at that same edge: zero cycles after the last bit is sampled.
  - Back-to-back words need no idle cycles.
- Handshake:
  - out_valid stays 1 and parallel_out stays unchanged until a posedge with out_ready=1.
  - At that edge out_valid clears, unless a new word completes at the same edge (see below).
  - out_ready has no effect while out_valid=0.
- Simultaneous accept and complete: the new word loads, out_valid stays 1, and no overrun is flagged.
- Overrun: a word completes while out_valid=1 and out_ready=0.
  - The new word is dropped and the held word is kept.
  - overrun is set at that edge and bit_cnt still wraps to 0.
  - overrun holds until overrun_clr=1 at a posedge. If the set and clear conditions coincide, set wins.
- sync_clr=1: at the posedge, bit_cnt=0 and the shift register is cleared; any shift_en in that cycle is ignored. The holding register, out_valid and overrun are unaffected.
- busy is combinational from bit_cnt != 0.
- bit_cnt width is clog2(WIDTH+2).

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - Frame is WIDTH data bits followed by one even-parity bit.
  - The parity bit is not stored in parallel_out.
  - parity_err = XOR of the WIDTH data bits and the parity bit, registered with parallel_out. It updates only when a word is loaded into the holding register and reads 1 on a mismatch.
- Undefined:
  - Frame is WIDTH bits.
  - parity_err is tied to 0.
  - No parity logic is synthesized.

Test Plan:
- Reset then idle: reset_n low for 20ns, released -> all outputs 0, busy=0.
- WIDTH=4, MSB_FIRST=1, serial 1,0,1,1 with shift_en high for 4 cycles and out_ready=1 -> parallel_out=4'b1011 and out_valid=1 right after the 4th edge, cleared one edge later. Repeat with 1,1,0,0 -> 4'b1100. Repeat with 0,1,1,0 -> 4'b0110.
- MSB_FIRST=0, serial 1,0,1,1 -> parallel_out=4'b1101.
- Overrun: out_ready=0, send 1011 then 0110 -> parallel_out stays 1011 and overrun=1. Pulse overrun_clr -> overrun=0. Assert out_ready -> out_valid=0.
- Resync and reset mid-word: shift in 2 bits, pulse sync_clr, send 1100 -> parallel_out=4'b1100. Shift in 2 bits, pulse reset_n low -> busy=0 and out_valid=0 immediately, with no clock edge needed.
- With SIPO_PARITY_CHECK_EN: send 1011+parity 1 -> parity_err=0. Send 1011+parity 0 -> parity_err=1, parallel_out=4'b1011.
